ahb_bus_arbiter: RTL

//  Shares one AHB bus (addr/burst/size/prot/write/wdata/strb/rdata) between N_MASTERS requesters.

---
 rtl/ahb_pkg.sv | 53 +++++
 rtl/ahb_rr_picker.sv | 44 ++++
 rtl/ahb_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
//  Module      : ahb_pkg (package)
//  Description : Shared AHB definitions: bus widths, HTRANS/HBURST encodings,
//                bus-arbiter state encoding and the burst-length helper.
//  Contents    : AHB_ADDR_WIDTH, AHB_DATA_WIDTH, htrans_e, hburst_e,
//                arb_state_e, burst_len()
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // Number of beats in a burst; 0 marks the undefined-length INCR burst.
  function automatic logic [4:0] burst_len(input hburst_e b);
    case (b)
      SINGLE:        return 5'd1;
      WRAP4, INCR4:  return 5'd4;
      WRAP8, INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:       return 5'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_picker.sv
// ============================================================================
//  Module      : ahb_rr_picker
//  Description : Combinational round-robin picker. Searches the request
//                vector starting at ptr+1, wrapping N_REQ-1 -> 0; the entry
//                at ptr itself is checked last.
//  Ports       : req    in  N_REQ  request vector
//                ptr    in  IW     index of the previous winner
//                winner out IW     selected index (0 when no request)
//                valid  out 1      at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [IW:0] N_W = (IW + 1)'(N_REQ);

  logic [IW:0] idx;

  // Walk from the farthest offset down to the nearest one so that the
  // last match written is the closest requester after ptr.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = {1'b0, ptr} + (IW + 1)'(i);
      if (idx >= N_W) idx = idx - N_W;
      if (req[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
//  Module      : ahb_bus_arbiter
//  Description : Round-robin AHB bus arbiter for N_MASTERS requesters. The
//                grant is held for the whole of a fixed-length burst and for
//                an INCR burst while the owner keeps requesting or keeps
//                issuing SEQ/BUSY. Master 0 is parked when nobody requests.
//  Config      : AHB_ARB_LOCK_EN - adds hlock_m; a locked owner keeps the
//                grant through arbitration points and drives hmastlock.
//  Ports       : clk          in   1            bus clock
//                rstn         in   1            async active-low reset
//                hbusreq      in   N_MASTERS    per-master request
//                htrans_m     in   2*N_MASTERS  per-master HTRANS
//                hburst_m     in   3*N_MASTERS  per-master HBURST
//                hlock_m      in   N_MASTERS    per-master lock (macro only)
//                hready       in   1            bus HREADY
//                hgrant       out  N_MASTERS    one-hot grant
//                hmaster      out  MW           address-phase owner
//                hmaster_data out  MW           data-phase owner
//                hmastlock    out  1            owner holds a locked transfer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter  int N_MASTERS = 4,
  localparam int MW        = $clog2(N_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_MASTERS-1:0]   hbusreq,
  input  logic [2*N_MASTERS-1:0] htrans_m,
  input  logic [3*N_MASTERS-1:0] hburst_m,
`ifdef AHB_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]   hlock_m,
`endif
  input  logic                   hready,
  output logic [N_MASTERS-1:0]   hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  arb_state_e           state, state_nx;
  logic [3:0]           beat_cnt, beat_nx;
  logic [MW-1:0]        rr_ptr, rr_nx, owner_nx;
  logic [N_MASTERS-1:0] grant_nx;
  logic                 arb_point;
  logic                 lock_hold, lock_nx;
  logic                 pick_valid;
  logic [MW-1:0]        pick_idx;

  logic [1:0]           trans_arr [N_MASTERS];
  logic [2:0]           burst_arr [N_MASTERS];
  htrans_e              own_trans;
  hburst_e              own_burst;
  logic [4:0]           own_len;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign trans_arr[g] = htrans_m[2*g +: 2];
    assign burst_arr[g] = hburst_m[3*g +: 3];
  end

  assign own_trans = htrans_e'(trans_arr[hmaster]);
  assign own_burst = hburst_e'(burst_arr[hmaster]);
  assign own_len   = burst_len(own_burst);

  ahb_rr_picker #(
    .N_REQ (N_MASTERS)
  ) u_picker (
    .req    (hbusreq),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = (state != ST_IDLE) && hlock_m[hmaster];
  assign lock_nx   = (state_nx != ST_IDLE) && hlock_m[owner_nx];
`else
  assign lock_hold = 1'b0;
  assign lock_nx   = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    beat_nx   = beat_cnt;
    rr_nx     = rr_ptr;
    owner_nx  = hmaster;
    arb_point = 1'b0;

    if (state == ST_IDLE) begin
      arb_point = |hbusreq;
    end else if (state == ST_BURST && own_trans == SEQ) begin
      if (beat_cnt <= 4'd1) begin
        beat_nx   = 4'd0;
        arb_point = 1'b1;
      end else begin
        beat_nx = beat_cnt - 4'd1;
      end
    end else if (state == ST_BURST && own_trans == BUSY) begin
      beat_nx = beat_cnt;
    end else begin
      // ST_OWN, or a burst cut short by IDLE/NONSEQ: evaluate as ST_OWN.
      beat_nx  = 4'd0;
      state_nx = ST_OWN;
      case (own_trans)
        NONSEQ: begin
          if (own_len > 5'd1) begin
            beat_nx  = 4'(own_len - 5'd1);
            state_nx = ST_BURST;
          end else if (own_burst == INCR) begin
            arb_point = !hbusreq[hmaster];
          end else begin
            arb_point = 1'b1;
          end
        end
        IDLE:    arb_point = 1'b1;
        default: arb_point = 1'b0;  // SEQ/BUSY continue an INCR burst
      endcase
    end

    if (arb_point) begin
      if (lock_hold) begin
        state_nx = ST_OWN;
      end else if (pick_valid) begin
        owner_nx = pick_idx;
        rr_nx    = pick_idx;
        state_nx = ST_OWN;
      end else begin
        owner_nx = '0;
        state_nx = ST_IDLE;
      end
    end

    grant_nx           = '0;
    grant_nx[owner_nx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      beat_cnt     <= 4'd0;
      rr_ptr       <= '0;
      hgrant       <= N_MASTERS'(1);
      hmaster      <= '0;
      hmaster_data <= '0;
      hmastlock    <= 1'b0;
    end else if (hready) begin
      state        <= state_nx;
      beat_cnt     <= beat_nx;
      rr_ptr       <= rr_nx;
      hgrant       <= grant_nx;
      hmaster      <= owner_nx;
      hmaster_data <= hmaster;
      hmastlock    <= lock_nx;
    end
  end

endmodule

`default_nettype wire
